// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for serial_adder_ctrl.
// The sub signal exists only when SERIAL_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

`ifdef SERIAL_SUB_EN
   modport master (output start, a, b, sub, input busy, done, sum, cout, overflow);
   modport slave  (input start, a, b, sub, output busy, done, sum, cout, overflow);
`else
   modport master (output start, a, b, input busy, done, sum, cout, overflow);
   modport slave  (input start, a, b, output busy, done, sum, cout, overflow);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared fullAdder cell, LSB first, one bit per clock.
// Define SERIAL_SUB_EN to add the sub input (A-B via ~B plus carry-in 1).
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               reset,
   serial_adder_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state, nxt;
   logic [WIDTH-1:0] sa, sb, sr;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             cmsb;
   logic             fa_sum, fa_carry;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;

   // Subtraction reuses the adder: A + ~B + 1.
`ifdef SERIAL_SUB_EN
   assign b_ld = bus.sub ? ~bus.b : bus.b;
   assign c_ld = bus.sub;
`else
   assign b_ld = bus.b;
   assign c_ld = 1'b0;
`endif

   assign last = (cnt == CW'(WIDTH - 1));
   assign cmsb = c;

   fullAdder u_fa (
      .a     (sa[0]),
      .b     (sb[0]),
      .cin   (c),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = RUN;
         RUN:     if (last) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sa           <= '0;
         sb           <= '0;
         sr           <= '0;
         c            <= 1'b0;
         cnt          <= '0;
         bus.sum      <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa  <= bus.a;
                  sb  <= b_ld;
                  c   <= c_ld;
                  cnt <= '0;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= {fa_sum, sr[WIDTH-1:1]};
               c   <= fa_carry;
               cnt <= cnt + 1'b1;
               // Final bit: results stay put until the next operation's final bit.
               if (last) begin
                  bus.sum      <= {fa_sum, sr[WIDTH-1:1]};
                  bus.cout     <= fa_carry;
                  bus.overflow <= cmsb ^ fa_carry;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8; subtraction cases need SERIAL_SUB_EN.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [7:0] s, input logic co, input logic ov);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(co));
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ov));
   endtask

   // lat = edges after the accepting edge until done is seen (-1 on timeout)
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         output int lat, output int bcnt);
      bus.start = 1'b1;
      bus.a = av;
      bus.b = bv;
`ifdef SERIAL_SUB_EN
      bus.sub = sv;
`endif
      tick;
      bus.start = 1'b0;
      lat = -1;
      bcnt = 0;
      for (int k = 0; k < 30; k++) begin
         chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat = k;
            break;
         end
         tick;
      end
      chk("op_no_timeout", 32'(lat >= 0), 32'd1);
   endtask

   task automatic no_done(input string tag, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         if (bus.done) seen++;
         tick;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int lat, bcnt, nd;
      int d[3];
      logic sv;
      sv = 1'b0;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
`ifdef SERIAL_SUB_EN
      bus.sub = 1'b0;
`endif
      tick;
      tick;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk_outs("rst", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      tick;

      run_op(8'h5A, 8'h3C, sv, lat, bcnt);
      chk("lat_5a3c", 32'(lat), 32'd8);
      chk("busy_len", 32'(bcnt), 32'd8);
      chk_outs("add_5a3c", 8'h96, 1'b0, 1'b1);
      tick;
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("sum_hold", 32'(bus.sum), 32'h96);

      run_op(8'hFF, 8'h01, sv, lat, bcnt);
      chk_outs("add_ff01", 8'h00, 1'b1, 1'b0);
      tick;
      run_op(8'h80, 8'h80, sv, lat, bcnt);
      chk_outs("add_8080", 8'h00, 1'b1, 1'b1);
      tick;

      // start held high: back-to-back operations every W+2 edges
      bus.start = 1'b1;
      bus.a = 8'h01;
      bus.b = 8'h02;
      tick;
      nd = 0;
      d = '{-1, -1, -1};
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            d[nd] = k;
            chk("held_sum", 32'(bus.sum), 32'h03);
            nd++;
            if (nd == 3) begin
               bus.start = 1'b0;
               break;
            end
         end
         tick;
      end
      chk("held_cnt", 32'(nd), 32'd3);
      chk("held_first", 32'(d[0]), 32'd8);
      chk("held_gap1", 32'(d[1] - d[0]), 32'd10);
      chk("held_gap2", 32'(d[2] - d[1]), 32'd10);
      tick;
      tick;

      // second start mid-RUN is ignored, operand changes too
      bus.start = 1'b1;
      bus.a = 8'h11;
      bus.b = 8'h22;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      tick;
      bus.start = 1'b1;
      bus.a = 8'h70;
      bus.b = 8'h70;
      tick;
      bus.start = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) begin
            lat = k;
            break;
         end
         tick;
      end
      chk("midrun_lat", 32'(lat), 32'd4);
      chk_outs("midrun", 8'h33, 1'b0, 1'b0);
      tick;
      no_done("midrun_no_extra", 12);
      chk("midrun_sum_hold", 32'(bus.sum), 32'h33);

      // reset during RUN cycle 4 discards the operation
      bus.start = 1'b1;
      bus.a = 8'h77;
      bus.b = 8'h11;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      tick;
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk_outs("midrst", 8'h00, 1'b0, 1'b0);
      no_done("midrst_no_done", 12);

      // reset wins over start on the same edge
      reset = 1'b1;
      bus.start = 1'b1;
      tick;
      reset = 1'b0;
      bus.start = 1'b0;
      chk("rst_prio_busy", 32'(bus.busy), 32'd0);
      tick;
      chk("rst_prio_idle", 32'(bus.busy), 32'd0);

      run_op(8'h12, 8'h34, sv, lat, bcnt);
      chk("lat_1234", 32'(lat), 32'd8);
      chk_outs("add_1234", 8'h46, 1'b0, 1'b0);
      tick;

`ifdef SERIAL_SUB_EN
      run_op(8'h10, 8'h20, 1'b1, lat, bcnt);
      chk_outs("sub_1020", 8'hF0, 1'b0, 1'b0);
      tick;
      run_op(8'h80, 8'h01, 1'b1, lat, bcnt);
      chk_outs("sub_8001", 8'h7F, 1'b1, 1'b1);
      tick;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
